// File: rtl/bsg_link_traffic_gen_check.sv
// rtl/bsg_link_traffic_gen_check.sv - LFSR traffic generator and checker for the DDR link core side.
// Optional DRAIN idle timeout: define BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN.
module bsg_link_traffic_gen_check #(
   parameter int width_p       = 64,
   parameter int count_width_p = 16,
   parameter int timeout_p     = 1024
) (
   input  logic                     core_clk_i,
   input  logic                     core_reset_n_i,
   input  logic                     start_i,
   input  logic [count_width_p-1:0] num_packets_i,
   input  logic [31:0]              seed_i,
   output logic [width_p-1:0]       data_o,
   output logic                     v_o,
   input  logic                     ready_and_i,
   input  logic [width_p-1:0]       data_i,
   input  logic                     v_i,
   output logic                     yumi_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pass_o,
   output logic [count_width_p-1:0] err_count_o,
   output logic [count_width_p-1:0] rx_count_o,
   output logic [count_width_p-1:0] first_err_idx_o,
   output logic                     timeout_o
);

   localparam int cw_lp = count_width_p;
   localparam logic [cw_lp-1:0] one_lp = cw_lp'(1);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   state_e            state_q, state_d;
   logic [31:0]       tx_lfsr_q, tx_lfsr_d, rx_lfsr_q, rx_lfsr_d;
   logic [cw_lp-1:0]  tx_cnt_q, tx_cnt_d, rx_count_q, rx_count_d;
   logic [cw_lp-1:0]  err_count_q, err_count_d, first_err_q, first_err_d;
   logic [cw_lp-1:0]  num_q, num_d;
   logic              stray_q, stray_d;
   logic              tx_hs, rx_window, rx_match, run_active;

`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
   logic [cw_lp-1:0]  idle_q, idle_d;
   logic              timeout_q, timeout_d;
`else
   logic              unused_timeout;
   assign unused_timeout = (timeout_p == 0);
`endif

   assign run_active = (state_q == SEND) || (state_q == DRAIN);
   assign v_o        = (state_q == SEND);
   assign data_o     = v_o ? {(width_p/32){tx_lfsr_q}} : '0;
   assign yumi_o     = v_i;
   assign busy_o     = run_active;
   assign done_o     = (state_q == DONE);
   assign tx_hs      = v_o & ready_and_i;
   assign rx_window  = run_active && (rx_count_q != num_q);
   assign rx_match   = (data_i == {(width_p/32){rx_lfsr_q}});

   always_comb begin
      state_d     = state_q;
      tx_lfsr_d   = tx_lfsr_q;
      rx_lfsr_d   = rx_lfsr_q;
      tx_cnt_d    = tx_cnt_q;
      rx_count_d  = rx_count_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      num_d       = num_q;
      stray_d     = stray_q;
`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
      idle_d      = '0;
      timeout_d   = timeout_q;
`endif

      // Words outside the expected window are strays: counted, never checked.
      if (v_i) begin
         if (rx_window) begin
            rx_lfsr_d  = lfsr_next(rx_lfsr_q);
            rx_count_d = rx_count_q + one_lp;
            if (!rx_match) begin
               if (err_count_q != '1) err_count_d = err_count_q + one_lp;
               if (first_err_q == '1) first_err_d = rx_count_q;
            end
         end else begin
            stray_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + one_lp;
         end
      end

      case (state_q)
         SEND: begin
            if (tx_hs) begin
               tx_lfsr_d = lfsr_next(tx_lfsr_q);
               tx_cnt_d  = tx_cnt_q + one_lp;
               if (tx_cnt_q == num_q - one_lp)
                  state_d = (rx_count_d == num_q) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (rx_count_d == num_q) begin
               state_d = DONE;
`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
            end else if (!v_i) begin
               if (idle_q == cw_lp'(timeout_p - 1)) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end else begin
                  idle_d = idle_q + one_lp;
               end
`endif
            end
         end
         default: ;
      endcase

      if (start_i && !run_active) begin
         tx_lfsr_d   = (seed_i == 32'h0) ? 32'h1 : seed_i;
         rx_lfsr_d   = (seed_i == 32'h0) ? 32'h1 : seed_i;
         tx_cnt_d    = '0;
         rx_count_d  = '0;
         err_count_d = '0;
         first_err_d = '1;
         num_d       = num_packets_i;
         stray_d     = 1'b0;
         state_d     = (num_packets_i != '0) ? SEND : DONE;
`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
         idle_d      = '0;
         timeout_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         state_q     <= IDLE;
         tx_lfsr_q   <= 32'h1;
         rx_lfsr_q   <= 32'h1;
         tx_cnt_q    <= '0;
         rx_count_q  <= '0;
         err_count_q <= '0;
         first_err_q <= '1;
         num_q       <= '0;
         stray_q     <= 1'b0;
`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
         idle_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tx_lfsr_q   <= tx_lfsr_d;
         rx_lfsr_q   <= rx_lfsr_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_count_q  <= rx_count_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
         num_q       <= num_d;
         stray_q     <= stray_d;
`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
         idle_q      <= idle_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign err_count_o     = err_count_q;
   assign rx_count_o      = rx_count_q;
   assign first_err_idx_o = first_err_q;
   assign pass_o          = done_o && (err_count_q == '0) && (rx_count_q == num_q)
                            && !stray_q && !timeout_o;

endmodule

// File: tb/tb_bsg_link_traffic_gen_check.sv
// tb/tb_bsg_link_traffic_gen_check.sv - scoreboard bench with a behavioural loopback for bsg_link_traffic_gen_check.
module tb_bsg_link_traffic_gen_check;

   localparam int W  = 64;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [CW-1:0] num_i;
   logic [31:0]   seed_i;
   logic [W-1:0]  data_o, data_i;
   logic          v_o, ready_and_i, v_i, yumi_o, busy_o, done_o, pass_o, timeout_o;
   logic [CW-1:0] err_o, rx_o, first_o;

   bsg_link_traffic_gen_check #(.width_p(W), .count_width_p(CW), .timeout_p(16)) dut (
      .core_clk_i(clk), .core_reset_n_i(rst_n), .start_i(start_i), .num_packets_i(num_i),
      .seed_i(seed_i), .data_o(data_o), .v_o(v_o), .ready_and_i(ready_and_i),
      .data_i(data_i), .v_i(v_i), .yumi_o(yumi_o), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .err_count_o(err_o), .rx_count_o(rx_o), .first_err_idx_o(first_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pass;
      logic [CW-1:0] err;
      logic [CW-1:0] rx;
      logic [CW-1:0] first;
      logic          tmo;
   } st_t;

   // LFSR sequence from seed 1, worked out by hand.
   logic [31:0] tbl [8] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                            32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003};

   logic [W-1:0] exp_tx [$];
   st_t          exp_st [$];
   logic [W-1:0] lb_q   [$];

   int vectors = 0, miscompares = 0;
   int hs_cnt = 0, done_cnt = 0, flip_idx = -1, drop_idx = -1;
   bit rdy_mode = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Loopback link model and TX ready pattern.
   always @(posedge clk) begin
      #1;
      ready_and_i = rdy_mode ? ~ready_and_i : 1'b1;
      if (lb_q.size() > 0) begin
         data_i = lb_q.pop_front();
         v_i    = 1'b1;
      end else begin
         data_i = '0;
         v_i    = 1'b0;
      end
   end

   // Monitor: TX scoreboard, stall stability, yumi, completion status.
   logic [W-1:0] held_d, w;
   bit           held_v = 0, done_prev = 0, pending = 0;
   st_t          s;
   always @(negedge clk) begin
      if (!rst_n) begin
         held_v = 0; done_prev = 0; pending = 0;
      end else begin
         if (held_v && v_o) chk("tx_stall_stable", data_o, held_d);
         held_v = v_o && !ready_and_i;
         held_d = data_o;
         if (v_i) chk("yumi", {63'h0, yumi_o}, {63'h0, v_i});
         if (v_o && ready_and_i) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", data_o, '0 - 1);
            else chk("tx_word", data_o, exp_tx.pop_front());
            w = data_o;
            if (hs_cnt == flip_idx) w[0] = ~w[0];
            if (hs_cnt != drop_idx) lb_q.push_back(w);
            hs_cnt++;
         end
         if (done_o && (pending || !done_prev)) begin
            done_cnt++;
            if (exp_st.size() == 0) chk("status_unexpected", 64'(done_o), 64'h0);
            else begin
               s = exp_st.pop_front();
               chk("pass", 64'(pass_o), 64'(s.pass));
               chk("err_count", 64'(err_o), 64'(s.err));
               chk("rx_count", 64'(rx_o), 64'(s.rx));
               chk("first_err_idx", 64'(first_o), 64'(s.first));
               chk("timeout", 64'(timeout_o), 64'(s.tmo));
            end
         end
         pending   = start_i && !busy_o;
         done_prev = done_o;
      end
   end

   task automatic start_run(input int num);
      @(posedge clk); #2;
      hs_cnt  = 0;
      for (int i = 0; i < num; i++) exp_tx.push_back({tbl[i], tbl[i]});
      start_i = 1'b1;
      num_i   = CW'(num);
      seed_i  = 32'h1;
      @(posedge clk); #2;
      start_i = 1'b0;
   endtask

   task automatic run(input int num, input logic pass, input int err, input int rx,
                      input logic [CW-1:0] first, input logic tmo);
      int d0;
      exp_st.push_back('{pass: pass, err: CW'(err), rx: CW'(rx), first: first, tmo: tmo});
      d0 = done_cnt;
      start_run(num);
      for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
      if (done_cnt == d0) chk("done_wait_timeout", 64'(done_cnt), 64'(d0 + 1));
      chk("tx_handshakes", 64'(hs_cnt), 64'(num));
      chk("tx_queue_empty", 64'(exp_tx.size()), 64'h0);
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; num_i = '0; seed_i = '0;
      ready_and_i = 1'b1; v_i = 1'b0; data_i = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_v_o", 64'(v_o), 64'h0);
      chk("rst_data_o", data_o, 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_done", 64'(done_o), 64'h0);
      chk("rst_pass", 64'(pass_o), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      chk("rst_rx", 64'(rx_o), 64'h0);
      chk("rst_first", 64'(first_o), 64'hFFFF);
      chk("rst_timeout", 64'(timeout_o), 64'h0);
      rst_n = 1'b1;

      run(4, 1'b1, 0, 4, 16'hFFFF, 1'b0);
      flip_idx = 2;
      run(4, 1'b0, 1, 4, 16'h0002, 1'b0);
      flip_idx = -1;
      rdy_mode = 1'b1;
      run(8, 1'b1, 0, 8, 16'hFFFF, 1'b0);
      rdy_mode = 1'b0;
      run(0, 1'b1, 0, 0, 16'hFFFF, 1'b0);

      // Stray word while DONE.
      lb_q.push_back(64'h1234_5678_9ABC_DEF0);
      repeat (3) @(posedge clk);
      #2;
      chk("stray_err", 64'(err_o), 64'h1);
      chk("stray_pass", 64'(pass_o), 64'h0);
      chk("stray_done", 64'(done_o), 64'h1);
      run(4, 1'b1, 0, 4, 16'hFFFF, 1'b0);

`ifdef BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN
      drop_idx = 3;
      run(4, 1'b0, 0, 3, 16'hFFFF, 1'b1);
      drop_idx = -1;
`endif

      // Reset in the middle of SEND.
      rdy_mode = 1'b1;
      start_run(8);
      repeat (3) @(posedge clk);
      #2;
      chk("mid_busy_before_reset", 64'(busy_o), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_v_o", 64'(v_o), 64'h0);
      chk("mid_rst_busy", 64'(busy_o), 64'h0);
      chk("mid_rst_rx", 64'(rx_o), 64'h0);
      chk("mid_rst_err", 64'(err_o), 64'h0);
      chk("mid_rst_first", 64'(first_o), 64'hFFFF);
      exp_tx.delete();
      rdy_mode = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("post_rst_v_o", 64'(v_o), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bsg_link_traffic_gen_check.md
Name: bsg_link_traffic_gen_check

Overview:
- Bring-up traffic generator and checker for the core side of a DDR link pearl.
- TX side drives the pearl's core input channel (valid/ready_and) with an LFSR-derived word stream.
- RX side consumes the pearl's core output channel (valid/yumi) and checks it against an identical, independently advanced LFSR.
- Used in loopback (tx routed back to rx through the off-chip link) to qualify link tuning settings, and reports pass/fail plus error statistics.

Parameters:
- width_p, 64, core data width; must be a multiple of 32.
- count_width_p, 16, width of the packet-count, error-count and index fields.
- timeout_p, 1024, idle-cycle limit in DRAIN; used only when the optional feature is compiled in.

Ports:
- core_clk_i  in  1  sole clock.
- core_reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle run request.
- num_packets_i  in  count_width_p  words to send/expect; sampled on an accepted start.
- seed_i  in  32  LFSR seed; sampled on an accepted start.
- data_o  out  width_p  TX word to the link core input.
- v_o  out  1  TX valid.
- ready_and_i  in  1  TX ready.
- data_i  in  width_p  RX word from the link core output.
- v_i  in  1  RX valid.
- yumi_o  out  1  RX dequeue.
- busy_o  out  1  run in progress (SEND or DRAIN).
- done_o  out  1  run complete (DONE state).
- pass_o  out  1  result; valid while done_o=1.
- err_count_o  out  count_width_p  mismatching RX words plus stray words; saturating.
- rx_count_o  out  count_width_p  expected-window RX words received.
- first_err_idx_o  out  count_width_p  RX index of the first mismatch.
- timeout_o  out  1  DRAIN timed out (optional feature only; constant 0 otherwise).

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE.
  - All outputs 0, all counters 0, both LFSRs=1, first_err_idx_o=all-ones.
- LFSR:
  - 32-bit Galois, next = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0).
  - seed_i=0 is loaded as 1.
  - Word pattern = {width_p/32 copies of LFSR state}.
- States IDLE, SEND, DRAIN, DONE.
- IDLE/DONE + start_i=1:
  - Load both LFSRs from seed.
  - Clear tx_cnt, rx_count, err_count, stray flag, timeout.
  - Set first_err_idx=all-ones and latch num.
  - Next state SEND if num≠0, else DONE with pass_o=1.
- start_i while busy_o=1: ignored.
- SEND:
  - v_o=1, data_o=pattern(tx_lfsr); data_o is stable while v_o=1 and ready_and_i=0.
  - On v_o&ready_and_i: tx_lfsr advances and tx_cnt++.
  - Handshake with tx_cnt=num-1 → DRAIN, v_o=0 the next cycle.
  - If rx_count also reaches num in that same cycle → DONE directly.
- RX (all states):
  - yumi_o=v_i, combinational, with no bubble.
  - RX words are accepted during SEND even before TX completes.
- RX in SEND/DRAIN with rx_count<num:
  - Compare data_i to pattern(rx_lfsr).
  - Advance rx_lfsr and increment rx_count.
  - On mismatch: err_count++ (saturates at all-ones); if first_err_idx=all-ones, load it with the current rx_count.
- RX otherwise (IDLE, DONE, or rx_count=num): stray word.
  - Set the stray flag and increment err_count.
  - LFSR and rx_count unchanged.
- DRAIN: rx_count=num → DONE.
- DONE:
  - done_o=1.
  - pass_o = (err_count=0) & (rx_count=num) & !stray & !timeout.
  - Holds until the next start_i.
- Reset mid-run: immediate return to the reset state; no residual TX valid.

Optional Feature:
- Macro: BSG_LINK_TRAFFIC_GEN_CHECK_TIMEOUT_EN.
- Defined:
  - A count_width_p-bit idle counter runs in DRAIN; it clears on each RX handshake.
  - Reaching timeout_p-1 → DONE with timeout_o=1, pass_o=0.
- Undefined:
  - No counter; DRAIN waits indefinitely.
  - timeout_o tied to 0.

Test Plan:
- Loopback, width_p=64, seed=1, num=4, ready always 1:
  - TX words 0x00000001_00000001 then 0x80200003_80200003.
  - done_o after the last RX; pass_o=1, rx_count_o=4, err_count_o=0.
- Same run with RX word index 2 bit 0 flipped → err_count_o=1, first_err_idx_o=2, pass_o=0.
- ready_and_i toggling 1/0 every cycle, num=8 → data_o held stable while stalled; exactly 8 handshakes; pass_o=1.
- num=0 start → DONE the next cycle, pass_o=1, v_o never asserted.
- Extra RX word after rx_count=num (in DONE) → err_count_o=1, pass_o=0; a new start_i clears it.
- Timeout macro on, timeout_p=16, drop last RX word → timeout_o=1 and pass_o=0 16 cycles after the final RX. Separately: core_reset_n_i asserted mid-SEND → v_o=0 immediately and counters 0.
